// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_e  : ownership state (IDLE / OWN0 / OWN1)
//   TIMEOUT_DATA : read data returned with a forced ack
//   GRANT_*      : one-hot grant encodings driven on o_grant
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot grant for a given ownership state.
  function automatic logic [1:0] grant_of(arb_state_e st);
    case (st)
      OWN0:    grant_of = GRANT_M0;
      OWN1:    grant_of = GRANT_M1;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone bundle around the two-master arbiter: both master request/return
// sides plus the shared slave side.
//   slave  modport : arbiter view (takes master requests, drives the slave)
//   master modport : requester/peripheral view (drives requests and slave
//                    responses, observes acks and slave-side outputs)
// Parameters: AW address width, DW data width (byte selects DW/8).
interface wb_arbiter2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          i_m0_wb_cyc,  i_m1_wb_cyc;
  logic          i_m0_wb_stb,  i_m1_wb_stb;
  logic          i_m0_wb_we,   i_m1_wb_we;
  logic [SW-1:0] i_m0_wb_sel,  i_m1_wb_sel;
  logic [AW-1:0] i_m0_wb_addr, i_m1_wb_addr;
  logic [DW-1:0] i_m0_wb_data, i_m1_wb_data;
  logic          o_m0_wb_ack,  o_m1_wb_ack;
  logic [DW-1:0] o_m0_wb_data, o_m1_wb_data;

  logic          o_s_wb_cyc, o_s_wb_stb, o_s_wb_we;
  logic [SW-1:0] o_s_wb_sel;
  logic [AW-1:0] o_s_wb_addr;
  logic [DW-1:0] o_s_wb_data;
  logic          i_s_wb_ack;
  logic [DW-1:0] i_s_wb_data;

  modport slave (
    input  i_m0_wb_cyc, i_m1_wb_cyc, i_m0_wb_stb, i_m1_wb_stb,
    input  i_m0_wb_we, i_m1_wb_we, i_m0_wb_sel, i_m1_wb_sel,
    input  i_m0_wb_addr, i_m1_wb_addr, i_m0_wb_data, i_m1_wb_data,
    output o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_data, o_m1_wb_data,
    output o_s_wb_cyc, o_s_wb_stb, o_s_wb_we, o_s_wb_sel,
    output o_s_wb_addr, o_s_wb_data,
    input  i_s_wb_ack, i_s_wb_data
  );

  modport master (
    output i_m0_wb_cyc, i_m1_wb_cyc, i_m0_wb_stb, i_m1_wb_stb,
    output i_m0_wb_we, i_m1_wb_we, i_m0_wb_sel, i_m1_wb_sel,
    output i_m0_wb_addr, i_m1_wb_addr, i_m0_wb_data, i_m1_wb_data,
    input  o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_data, o_m1_wb_data,
    input  o_s_wb_cyc, o_s_wb_stb, o_s_wb_we, o_s_wb_sel,
    input  o_s_wb_addr, o_s_wb_data,
    output i_s_wb_ack, i_s_wb_data
  );

endinterface

// File: rtl/wb_arb_timeout.sv
// Stall counter for the arbiter's forced-ack path.
//   clk, reset : clock, synchronous active-high reset
//   stb        : slave-side strobe of the current owner
//   ack        : real slave ack
//   clr        : ownership is ending / absent
//   expire     : stall limit hit this cycle (and no real ack), forces an ack
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic expire
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;

  // A real ack in the same cycle always wins over the forced one.
  assign expire = stb && !ack && (cnt == CW'(TIMEOUT_CYCLES));

  // Counts consecutive stb-without-ack cycles; restarts on any break.
  always_ff @(posedge clk) begin
    if (reset || clr || !stb || ack || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter, round-robin per cyc frame.
// Ownership is held until the granted master drops cyc; an IDLE cycle always
// separates two ownerships.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_arbiter2_if.slave (master requests/returns, slave side)
//   o_grant    : one-hot current owner, 00 when idle
//   o_timeout  : one-cycle pulse on a forced ack
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall timeout that forces an
// ack with TIMEOUT_DATA after TIMEOUT_CYCLES stalled strobe cycles.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned LAST_INIT      = 1
) (
  input  logic           clk,
  input  logic           reset,
  wb_arbiter2_if.slave   bus,
  output logic [1:0]     o_grant,
  output logic           o_timeout
);
  localparam int unsigned SW = DW / 8;

  arb_state_e    state;
  logic          last;      // 1: m1 owned most recently, so m0 wins a tie
  logic          own0, own1;
  logic          rsp_ack;
  logic [DW-1:0] rsp_data;
  logic          s_stb;

  // Ownership state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'(LAST_INIT);
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_m0_wb_cyc && bus.i_m1_wb_cyc) begin
            state <= last ? OWN0 : OWN1;
          end else if (bus.i_m0_wb_cyc) begin
            state <= OWN0;
          end else if (bus.i_m1_wb_cyc) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!bus.i_m0_wb_cyc) begin
            state <= IDLE;
            last  <= 1'b0;
          end
        end
        OWN1: begin
          if (!bus.i_m1_wb_cyc) begin
            state <= IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign o_grant = grant_of(state);

  // Slave-side mux; everything quiet while idle.
  always_comb begin
    bus.o_s_wb_cyc  = 1'b0;
    bus.o_s_wb_stb  = 1'b0;
    bus.o_s_wb_we   = 1'b0;
    bus.o_s_wb_sel  = '0;
    bus.o_s_wb_addr = '0;
    bus.o_s_wb_data = '0;
    if (own0) begin
      bus.o_s_wb_cyc  = bus.i_m0_wb_cyc;
      bus.o_s_wb_stb  = bus.i_m0_wb_stb;
      bus.o_s_wb_we   = bus.i_m0_wb_we;
      bus.o_s_wb_sel  = SW'(bus.i_m0_wb_sel);
      bus.o_s_wb_addr = AW'(bus.i_m0_wb_addr);
      bus.o_s_wb_data = DW'(bus.i_m0_wb_data);
    end else if (own1) begin
      bus.o_s_wb_cyc  = bus.i_m1_wb_cyc;
      bus.o_s_wb_stb  = bus.i_m1_wb_stb;
      bus.o_s_wb_we   = bus.i_m1_wb_we;
      bus.o_s_wb_sel  = SW'(bus.i_m1_wb_sel);
      bus.o_s_wb_addr = AW'(bus.i_m1_wb_addr);
      bus.o_s_wb_data = DW'(bus.i_m1_wb_data);
    end
  end

  assign s_stb = own0 ? bus.i_m0_wb_stb : (own1 ? bus.i_m1_wb_stb : 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
  logic expire;
  logic clr;

  // Counter restarts whenever there is no owner or the owner is releasing.
  assign clr = (state == IDLE) || (own0 && !bus.i_m0_wb_cyc) ||
               (own1 && !bus.i_m1_wb_cyc);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .stb    (s_stb),
    .ack    (bus.i_s_wb_ack),
    .clr    (clr),
    .expire (expire)
  );

  assign rsp_ack   = bus.i_s_wb_ack || expire;
  assign rsp_data  = expire ? DW'(TIMEOUT_DATA) : DW'(bus.i_s_wb_data);
  assign o_timeout = expire;
`else
  logic unused_stb;
  assign unused_stb = s_stb;
  assign rsp_ack    = bus.i_s_wb_ack;
  assign rsp_data   = DW'(bus.i_s_wb_data);
  assign o_timeout  = 1'b0;
`endif

  // Responses reach only the owner; a stray ack while idle is dropped.
  assign bus.o_m0_wb_ack  = rsp_ack && own0;
  assign bus.o_m1_wb_ack  = rsp_ack && own1;
  assign bus.o_m0_wb_data = own0 ? rsp_data : '0;
  assign bus.o_m1_wb_data = own1 ? rsp_data : '0;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: single-master transfer, tie-break and
// handoff, held ownership, stray ack, reset abort, stall timeout behaviour.
module tb_wb_arbiter2;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       timeout;
  int         checks = 0;
  int         failures = 0;

  localparam logic [31:0] A0 = 32'h3000_0000;
  localparam logic [31:0] A1 = 32'h3000_0100;
  localparam logic [31:0] D0 = 32'h1234_5678;

  wb_arbiter2_if #(.AW(32), .DW(32)) bus ();

  wb_arbiter2 #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (8),
    .LAST_INIT      (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .o_grant   (grant),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    bus.i_m0_wb_cyc = 0; bus.i_m0_wb_stb = 0; bus.i_m0_wb_we = 0;
    bus.i_m0_wb_sel = 0; bus.i_m0_wb_addr = 0; bus.i_m0_wb_data = 0;
    bus.i_m1_wb_cyc = 0; bus.i_m1_wb_stb = 0; bus.i_m1_wb_we = 0;
    bus.i_m1_wb_sel = 0; bus.i_m1_wb_addr = 0; bus.i_m1_wb_data = 0;
    bus.i_s_wb_ack  = 0; bus.i_s_wb_data = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_cyc", 64'(bus.o_s_wb_cyc), 64'h0);
    chk("rst_s_stb", 64'(bus.o_s_wb_stb), 64'h0);
    chk("rst_m0_ack", 64'(bus.o_m0_wb_ack), 64'h0);
    chk("rst_m1_ack", 64'(bus.o_m1_wb_ack), 64'h0);
    chk("rst_timeout", 64'(timeout), 64'h0);
    reset = 1'b0;

    // m0 alone: write, slave acks two cycles after stb appears
    tick();
    bus.i_m0_wb_cyc = 1; bus.i_m0_wb_stb = 1; bus.i_m0_wb_we = 1;
    bus.i_m0_wb_sel = 4'hF; bus.i_m0_wb_addr = A0; bus.i_m0_wb_data = D0;
    #1;
    chk("t1_stb_same_cycle", 64'(bus.o_s_wb_stb), 64'h0);
    chk("t1_grant_same_cycle", 64'(grant), 64'h0);
    tick(); #1;
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_s_stb", 64'(bus.o_s_wb_stb), 64'h1);
    chk("t1_s_we", 64'(bus.o_s_wb_we), 64'h1);
    chk("t1_s_sel", 64'(bus.o_s_wb_sel), 64'hF);
    chk("t1_s_addr", 64'(bus.o_s_wb_addr), 64'(A0));
    chk("t1_s_data", 64'(bus.o_s_wb_data), 64'(D0));
    tick(); #1;
    chk("t1_no_ack_yet", 64'(bus.o_m0_wb_ack), 64'h0);
    tick();
    bus.i_s_wb_ack = 1;
    #1;
    chk("t1_m0_ack", 64'(bus.o_m0_wb_ack), 64'h1);
    chk("t1_m1_ack", 64'(bus.o_m1_wb_ack), 64'h0);
    tick();
    bus.i_s_wb_ack = 0;
    bus.i_m0_wb_cyc = 0; bus.i_m0_wb_stb = 0; bus.i_m0_wb_we = 0;
    #1;
    chk("t1_ack_one_cycle", 64'(bus.o_m0_wb_ack), 64'h0);
    tick(); #1;
    chk("t1_idle_grant", 64'(grant), 64'h0);
    chk("t1_idle_s_cyc", 64'(bus.o_s_wb_cyc), 64'h0);

    // tie after reset goes to m0, then one IDLE cycle, then m1
    do_reset();
    bus.i_m0_wb_cyc = 1; bus.i_m0_wb_stb = 1; bus.i_m0_wb_addr = A0;
    bus.i_m1_wb_cyc = 1; bus.i_m1_wb_stb = 1; bus.i_m1_wb_addr = A1;
    tick(); #1;
    chk("t2_tie_grant", 64'(grant), 64'h1);
    chk("t2_tie_addr", 64'(bus.o_s_wb_addr), 64'(A0));
    tick();
    bus.i_m0_wb_cyc = 0; bus.i_m0_wb_stb = 0;
    tick(); #1;
    chk("t2_gap_grant", 64'(grant), 64'h0);
    chk("t2_gap_s_cyc", 64'(bus.o_s_wb_cyc), 64'h0);
    tick(); #1;
    chk("t2_m1_grant", 64'(grant), 64'h2);
    chk("t2_m1_addr", 64'(bus.o_s_wb_addr), 64'(A1));

    // m1 holds cyc across three reads while m0 waits
    bus.i_m0_wb_cyc = 1; bus.i_m0_wb_stb = 1;
    for (int k = 0; k < 3; k++) begin
      bus.i_s_wb_ack = 1;
      bus.i_s_wb_data = 32'hC0DE_0000 + 32'(k);
      #1;
      chk("t3_m1_ack", 64'(bus.o_m1_wb_ack), 64'h1);
      chk("t3_m1_data", 64'(bus.o_m1_wb_data), 64'(32'hC0DE_0000 + 32'(k)));
      chk("t3_m0_ack", 64'(bus.o_m0_wb_ack), 64'h0);
      chk("t3_m0_data", 64'(bus.o_m0_wb_data), 64'h0);
      chk("t3_grant", 64'(grant), 64'h2);
      tick();
      bus.i_s_wb_ack = 0;
      bus.i_s_wb_data = 0;
      tick();
    end
    bus.i_m1_wb_cyc = 0; bus.i_m1_wb_stb = 0;
    tick(); #1;
    chk("t3_gap_grant", 64'(grant), 64'h0);
    chk("t3_gap_s_cyc", 64'(bus.o_s_wb_cyc), 64'h0);
    tick(); #1;
    chk("t3_m0_grant", 64'(grant), 64'h1);
    chk("t3_m0_s_cyc", 64'(bus.o_s_wb_cyc), 64'h1);
    chk("t3_m0_addr", 64'(bus.o_s_wb_addr), 64'(A0));
    bus.i_m0_wb_cyc = 0; bus.i_m0_wb_stb = 0;
    tick();

    // stray slave ack while idle
    bus.i_s_wb_ack = 1; bus.i_s_wb_data = 32'hA5A5_A5A5;
    #1;
    chk("t4_grant", 64'(grant), 64'h0);
    chk("t4_m0_ack", 64'(bus.o_m0_wb_ack), 64'h0);
    chk("t4_m1_ack", 64'(bus.o_m1_wb_ack), 64'h0);
    chk("t4_m0_data", 64'(bus.o_m0_wb_data), 64'h0);
    chk("t4_m1_data", 64'(bus.o_m1_wb_data), 64'h0);
    tick();
    bus.i_s_wb_ack = 0; bus.i_s_wb_data = 0;

    // reset in the middle of an m0 transfer
    bus.i_m0_wb_cyc = 1; bus.i_m0_wb_stb = 1;
    tick(); #1;
    chk("t5_pre_grant", 64'(grant), 64'h1);
    reset = 1'b1;
    tick();
    bus.i_s_wb_ack = 1;
    #1;
    chk("t5_s_cyc", 64'(bus.o_s_wb_cyc), 64'h0);
    chk("t5_s_stb", 64'(bus.o_s_wb_stb), 64'h0);
    chk("t5_grant", 64'(grant), 64'h0);
    chk("t5_m0_ack", 64'(bus.o_m0_wb_ack), 64'h0);
    reset = 1'b0;
    bus.i_s_wb_ack = 0;
    bus.i_m1_wb_cyc = 1; bus.i_m1_wb_stb = 1;
    tick(); #1;
    chk("t5_tie_after_reset", 64'(grant), 64'h1);
    clear_inputs();
    tick();

    // slave never acks
    do_reset();
    bus.i_m0_wb_cyc = 1; bus.i_m0_wb_stb = 1;
    tick();
    seen = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.o_m0_wb_ack || timeout) seen = 1'b1;
      tick();
    end
    #1;
    chk("t6_no_early_ack", 64'(seen), 64'h0);
    chk("t6_forced_ack", 64'(bus.o_m0_wb_ack), 64'h1);
    chk("t6_forced_data", 64'(bus.o_m0_wb_data), 64'hDEAD_BEEF);
    chk("t6_timeout", 64'(timeout), 64'h1);
    chk("t6_m1_ack", 64'(bus.o_m1_wb_ack), 64'h0);
    tick(); #1;
    chk("t6_ack_pulse", 64'(bus.o_m0_wb_ack), 64'h0);
    chk("t6_timeout_pulse", 64'(timeout), 64'h0);
`else
    for (int k = 0; k < 1000; k++) begin
      #1;
      if (bus.o_m0_wb_ack || timeout) seen = 1'b1;
      tick();
    end
    chk("t6_no_ack_1000", 64'(seen), 64'h0);
    chk("t6_still_owned", 64'(grant), 64'h1);
`endif
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the user-area Wishbone peripheral (wb_test class slave).
- Master 0 is the management SoC Wishbone port. Master 1 is a secondary on-chip requester, such as an LA-driven bus driver.
- Grants are round-robin per bus cycle (cyc-framed). Ownership is held until the granted master drops cyc.

Parameters:
- AW, 32, address width
- DW, 32, data width; byte selects are DW/8
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before a forced ack (only with WB_ARB_TIMEOUT_EN)
- LAST_INIT, 1, reset value of last-granted pointer; 1 means master 0 wins the first tie

Ports:
- clk input 1 system clock (wb_clk_i)
- reset input 1 synchronous active-high reset (wb_rst_i)
- i_m0_wb_cyc, i_m1_wb_cyc input 1 each: master cycle
- i_m0_wb_stb, i_m1_wb_stb input 1 each: master strobe
- i_m0_wb_we, i_m1_wb_we input 1 each: master write enable
- i_m0_wb_sel, i_m1_wb_sel input DW/8 each: byte selects
- i_m0_wb_addr, i_m1_wb_addr input AW each: address
- i_m0_wb_data, i_m1_wb_data input DW each: write data
- o_m0_wb_ack, o_m1_wb_ack output 1 each: per-master ack
- o_m0_wb_data, o_m1_wb_data output DW each: per-master read data
- o_s_wb_cyc, o_s_wb_stb, o_s_wb_we output 1 each: to slave
- o_s_wb_sel output DW/8: to slave
- o_s_wb_addr output AW: to slave
- o_s_wb_data output DW: to slave
- i_s_wb_ack input 1: slave ack
- i_s_wb_data input DW: slave read data
- o_grant output 2: one-hot current owner; 00 when idle
- o_timeout output 1: one-cycle pulse on forced ack

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, sampled on rising edge; all registers clear on that edge.
- FSM states: IDLE, OWN0, OWN1. Registered state plus registered last pointer.
- IDLE transitions:
  - Only m0 cyc high -> OWN0.
  - Only m1 cyc high -> OWN1.
  - Both high -> the master not equal to last.
  - Neither high -> stay IDLE.
- Grant latency: a transition out of IDLE takes effect at the next edge, so the first slave stb appears no earlier than 1 cycle after the master's cyc.
- OWNx: stay while i_mx_wb_cyc=1. When it is 0 at an edge -> IDLE and last<=x.
- Back-to-back handoff: at least one IDLE cycle always separates two ownerships, so the slave sees cyc low for at least 1 cycle. A master raising cyc in the same cycle the other drops is granted after that IDLE cycle.
- Slave-side mux (combinational from state):
  - OWNx: all o_s_* equal master x inputs.
  - IDLE: o_s_wb_cyc=0, o_s_wb_stb=0, o_s_wb_we=0, o_s_wb_sel=0, o_s_wb_addr=0, o_s_wb_data=0.
- Master-side returns:
  - o_mx_wb_ack = i_s_wb_ack AND (state==OWNx).
  - o_mx_wb_data = i_s_wb_data when OWNx, else 0.
  - A non-owning master never sees ack, even if its own stb is high.
- o_grant: OWN0 -> 01, OWN1 -> 10, IDLE -> 00.
- A stray i_s_wb_ack in IDLE is ignored and never forwarded.
- Reset mid-transfer: state<=IDLE, last<=LAST_INIT, counter<=0. Slave cyc/stb drop in the cycle after the reset edge. No ack is produced for the aborted transfer.
- Reset values of outputs: all outputs 0, o_grant=00, o_timeout=0.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle with o_s_wb_stb=1 and i_s_wb_ack=0.
  - Counter clears on ack, on stb low, and on leaving OWNx.
  - When the count reaches TIMEOUT_CYCLES: owner gets a one-cycle ack with data 32'hDEADBEEF (truncated/zero-extended to DW), o_timeout pulses 1 cycle, and the counter clears.
  - A real slave ack arriving in the same cycle wins; no timeout is raised.
- Undefined: no counter, o_timeout tied 0, and the arbiter waits indefinitely for ack.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1}
  - TIMEOUT_DATA = 32'hDEADBEEF
  - grant one-hot encodings
- One sub-module, wb_arb_timeout: the stall counter with inputs clk, reset, stb, ack, clr and output expire. It is instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- m0 alone: write addr 0x3000_0000 data 0x1234_5678, slave acks 2 cycles after stb -> o_s_wb_stb rises 1 cycle after cyc, o_m0_wb_ack=1 for 1 cycle, o_grant=01, o_m1_wb_ack stays 0.
- Both raise cyc on the same edge after reset -> m0 granted first (LAST_INIT=1). After m0 drops cyc: 1 IDLE cycle, then OWN1 with o_grant=10.
- m1 holds cyc across 3 reads while m0 requests -> m0 waits all 3. Ownership passes only after m1 cyc drops, with exactly 1 IDLE cycle on the slave bus.
- Slave asserts ack while IDLE -> no master ack; slave data forwarded as 0 to both masters.
- Reset asserted mid-transfer in OWN0 -> next cycle o_s_wb_cyc=0 and o_grant=00; after release, a tie goes to m0.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> after 8 stall cycles the owner gets ack with data 0xDEADBEEF and o_timeout pulses 1 cycle. Without the macro, no ack arrives within 1000 cycles.
